// File: rtl/ring_seq_pkg.sv
// Shared types and constants for the ring sequencer slice.
package ring_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic DIR_MSB = 1'b0;
  localparam logic DIR_LSB = 1'b1;

  localparam int RING_W_DFLT = 4;
  localparam int STEP_W_DFLT = 8;
  localparam int DIV_W_DFLT  = 8;

  localparam logic [RING_W_DFLT-1:0] RING_RESET_VAL = 4'b0001;

endpackage

// File: rtl/ring_seq_ctrl_if.sv
// Command handshake between the control-side decode and the ring sequencer.
interface ring_seq_ctrl_if
  import ring_seq_pkg::*;
#(
  parameter int RING_W = RING_W_DFLT,
  parameter int STEP_W = STEP_W_DFLT,
  parameter int DIV_W  = DIV_W_DFLT
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_dir;
  logic [STEP_W-1:0] cmd_steps;
  logic [DIV_W-1:0]  cmd_div;
  logic [RING_W-1:0] cmd_seed;

  modport master (
    output cmd_valid, cmd_dir, cmd_steps, cmd_div, cmd_seed,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_steps, cmd_div, cmd_seed,
    output cmd_ready
  );
endinterface

// File: rtl/ring_shift_reg.sv
// Rotating ring register: synchronous load (priority) or one-place rotate.
module ring_shift_reg
  import ring_seq_pkg::*;
#(
  parameter int RING_W = RING_W_DFLT
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              load,
  input  logic [RING_W-1:0] load_val,
  input  logic              shift_en,
  input  logic              dir,
  output logic [RING_W-1:0] q
);
  localparam logic [RING_W-1:0] RST_VAL = RING_W'(RING_RESET_VAL);

  logic [RING_W-1:0] ring_q, ring_d;

  always_comb begin
    ring_d = ring_q;
    if (load) begin
      ring_d = load_val;
    end else if (shift_en) begin
      ring_d = (dir == DIR_LSB) ? {ring_q[0], ring_q[RING_W-1:1]}
                                : {ring_q[RING_W-2:0], ring_q[RING_W-1]};
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) ring_q <= RST_VAL;
    else       ring_q <= ring_d;
  end

  assign q = ring_q;

endmodule

// File: rtl/ring_seq_ctrl.sv
// Command-driven ring sequencer: load a seed, rotate N times every (div+1)
// clocks, then pulse done. Abort drops straight back to IDLE.
module ring_seq_ctrl
  import ring_seq_pkg::*;
#(
  parameter int RING_W = RING_W_DFLT,
  parameter int STEP_W = STEP_W_DFLT,
  parameter int DIV_W  = DIV_W_DFLT
) (
  input  logic              Clock,
  input  logic              Reset,
  ring_seq_ctrl_if.slave    cmd,
  input  logic              abort,
  output logic [RING_W-1:0] ring_out,
  output logic              busy,
  output logic              done_pulse,
  output logic [STEP_W-1:0] step_rem
);
  localparam logic [RING_W-1:0] RST_VAL = RING_W'(RING_RESET_VAL);

  state_e            state_q;
  logic [DIV_W-1:0]  divcnt_q;
  logic [STEP_W-1:0] step_rem_q;
  logic              dir_q;
  logic [STEP_W-1:0] steps_q;
  logic [DIV_W-1:0]  div_q;
  logic [RING_W-1:0] seed_q;

  logic              accept;
  logic              ring_load;
  logic              ring_shift;
  logic [RING_W-1:0] load_val;

  assign cmd.cmd_ready = (state_q == IDLE) && !Reset;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  // Abort suppresses both the load and a rotation that would fall on the same edge.
  assign ring_load  = (state_q == LOAD) && !abort;
  assign ring_shift = (state_q == RUN) && !abort && (divcnt_q == '0);
  assign load_val   = (seed_q == '0) ? RST_VAL : seed_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= IDLE;
      divcnt_q   <= '0;
      step_rem_q <= '0;
      dir_q      <= DIR_MSB;
      steps_q    <= '0;
      div_q      <= '0;
      seed_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            dir_q   <= cmd.cmd_dir;
            steps_q <= cmd.cmd_steps;
            div_q   <= cmd.cmd_div;
            seed_q  <= cmd.cmd_seed;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (abort) begin
            step_rem_q <= '0;
            state_q    <= IDLE;
          end else begin
            divcnt_q   <= div_q;
            step_rem_q <= steps_q;
            state_q    <= (steps_q == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (abort) begin
            step_rem_q <= '0;
            state_q    <= IDLE;
          end else if (divcnt_q != '0) begin
            divcnt_q <= divcnt_q - DIV_W'(1);
          end else begin
            divcnt_q   <= div_q;
            step_rem_q <= step_rem_q - STEP_W'(1);
            if (step_rem_q == STEP_W'(1)) state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  ring_shift_reg #(.RING_W(RING_W)) u_ring (
    .Clock    (Clock),
    .Reset    (Reset),
    .load     (ring_load),
    .load_val (load_val),
    .shift_en (ring_shift),
    .dir      (dir_q),
    .q        (ring_out)
  );

  assign busy       = (state_q != IDLE);
  assign done_pulse = (state_q == DONE);
  assign step_rem   = step_rem_q;

endmodule

// File: tb/tb_ring_seq_ctrl.sv
// Scoreboard bench for ring_seq_ctrl: expected ring/step_rem events are queued
// per command and retired on the edge they are due.
module tb_ring_seq_ctrl;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       abort = 1'b0;
  logic [3:0] ring_out;
  logic       busy;
  logic       done_pulse;
  logic [7:0] step_rem;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         edge_n;
    logic [3:0] ring;
    logic [7:0] srem;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] model_ring;

  ring_seq_ctrl_if #(.RING_W(4), .STEP_W(8), .DIV_W(8)) cmd_if ();

  ring_seq_ctrl #(.RING_W(4), .STEP_W(8), .DIV_W(8)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .cmd        (cmd_if),
    .abort      (abort),
    .ring_out   (ring_out),
    .busy       (busy),
    .done_pulse (done_pulse),
    .step_rem   (step_rem)
  );

  always #5 Clock = ~Clock;

  function automatic logic [3:0] rot(input logic [3:0] r, input logic d);
    if (d) return {r[0], r[3], r[2], r[1]};
    else   return {r[2], r[1], r[0], r[3]};
  endfunction

  // Issue one command and check every cycle until it is back in IDLE.
  // abort_at: edge (relative to accept) at which abort is sampled, -1 for none.
  task automatic run_cmd(input string name, input logic dir, input int steps,
                         input int div, input logic [3:0] seed,
                         input int abort_at, input bit abort_in_done);
    logic [3:0] r;
    logic [3:0] cur_ring;
    logic [7:0] cur_srem;
    int         done_edge, idle_edge, ev;
    exp_t       e;
    cur_ring  = model_ring;
    cur_srem  = 8'd0;
    done_edge = 1 + (div + 1) * steps;
    idle_edge = done_edge + 1;
    r         = model_ring;
    if (abort_at >= 0) begin
      done_edge = -1;
      idle_edge = abort_at;
    end
    if (abort_at < 0 || abort_at > 1) begin
      r = (seed == 4'b0) ? 4'b0001 : seed;
      sb.push_back('{1, r, 8'(steps)});
      for (int i = 1; i <= steps; i++) begin
        ev = 1 + (div + 1) * i;
        if (abort_at >= 0 && ev >= abort_at) break;
        r = rot(r, dir);
        sb.push_back('{ev, r, 8'(steps - i)});
      end
    end
    if (abort_at >= 0) sb.push_back('{abort_at, r, 8'd0});

    total++;
    if (cmd_if.cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s ready_before_accept got=%b exp=1", name, cmd_if.cmd_ready);
    end
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_dir   = dir;
    cmd_if.cmd_steps = 8'(steps);
    cmd_if.cmd_div   = 8'(div);
    cmd_if.cmd_seed  = seed;
    @(posedge Clock);
    #1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_dir   = 1'($urandom);
    cmd_if.cmd_steps = 8'($urandom);
    cmd_if.cmd_div   = 8'($urandom);
    cmd_if.cmd_seed  = 4'($urandom);

    for (int c = 0; c <= idle_edge; c++) begin
      while (sb.size() > 0 && sb[0].edge_n == c) begin
        e        = sb.pop_front();
        cur_ring = e.ring;
        cur_srem = e.srem;
      end
      @(negedge Clock);
      if (abort_in_done && c == done_edge) abort = 1'b1;
      total += 5;
      if (ring_out !== cur_ring) begin
        bad++;
        $display("FAIL %s ring c=%0d got=%b exp=%b", name, c, ring_out, cur_ring);
      end
      if (step_rem !== cur_srem) begin
        bad++;
        $display("FAIL %s step_rem c=%0d got=%0d exp=%0d", name, c, step_rem, cur_srem);
      end
      if (done_pulse !== (c == done_edge)) begin
        bad++;
        $display("FAIL %s done_pulse c=%0d got=%b exp=%b", name, c, done_pulse, (c == done_edge));
      end
      if (busy !== (c < idle_edge)) begin
        bad++;
        $display("FAIL %s busy c=%0d got=%b exp=%b", name, c, busy, (c < idle_edge));
      end
      if (cmd_if.cmd_ready !== (c >= idle_edge)) begin
        bad++;
        $display("FAIL %s cmd_ready c=%0d got=%b exp=%b", name, c, cmd_if.cmd_ready, (c >= idle_edge));
      end
      if (abort_at >= 0 && c + 1 == abort_at) abort = 1'b1;
      if (c < idle_edge) begin
        @(posedge Clock);
        #1;
        abort = 1'b0;
      end
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s scoreboard_left got=%0d exp=0", name, sb.size());
      sb.delete();
    end
    model_ring = cur_ring;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    total++;
    if (cmd_if.cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset ready_in_reset got=%b exp=0", cmd_if.cmd_ready);
    end
    @(posedge Clock);
    #1 Reset = 1'b0;
    @(negedge Clock);
    total += 5;
    if (ring_out !== 4'b0001) begin bad++; $display("FAIL reset ring got=%b exp=0001", ring_out); end
    if (cmd_if.cmd_ready !== 1'b1) begin bad++; $display("FAIL reset ready got=%b exp=1", cmd_if.cmd_ready); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset busy got=%b exp=0", busy); end
    if (done_pulse !== 1'b0) begin bad++; $display("FAIL reset done got=%b exp=0", done_pulse); end
    if (step_rem !== 8'd0) begin bad++; $display("FAIL reset step_rem got=%0d exp=0", step_rem); end
    model_ring = 4'b0001;
  endtask

  task automatic test_rotate_msb();
    run_cmd("rot_msb", 1'b0, 5, 0, 4'b0000, -1, 1'b0);
  endtask

  task automatic test_rotate_lsb_div();
    run_cmd("rot_lsb_div", 1'b1, 2, 2, 4'b1011, -1, 1'b0);
  endtask

  task automatic test_zero_steps();
    run_cmd("zero_steps", 1'b0, 0, 3, 4'b0110, -1, 1'b0);
  endtask

  task automatic test_abort();
    run_cmd("abort_run", 1'b0, 4, 1, 4'b0000, 5, 1'b0);
    run_cmd("abort_load", 1'b1, 3, 0, 4'b1000, 1, 1'b0);
    run_cmd("abort_done", 1'b1, 1, 0, 4'b0100, -1, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_dir   = 1'b0;
    cmd_if.cmd_steps = 8'd200;
    cmd_if.cmd_div   = 8'd7;
    cmd_if.cmd_seed  = 4'b0000;
    @(posedge Clock);
    #1 cmd_if.cmd_valid = 1'b0;
    repeat (20) @(posedge Clock);
    @(negedge Clock);
    total += 2;
    if (busy !== 1'b1) begin bad++; $display("FAIL midrst busy_before got=%b exp=1", busy); end
    if (step_rem !== 8'(200 - (20 - 1) / 8)) begin
      bad++;
      $display("FAIL midrst step_rem_before got=%0d exp=%0d", step_rem, 200 - (20 - 1) / 8);
    end
    Reset            = 1'b1;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_seed  = 4'b1001;
    cmd_if.cmd_steps = 8'd3;
    @(posedge Clock);
    @(negedge Clock);
    total += 4;
    if (ring_out !== 4'b0001) begin bad++; $display("FAIL midrst ring got=%b exp=0001", ring_out); end
    if (step_rem !== 8'd0) begin bad++; $display("FAIL midrst step_rem got=%0d exp=0", step_rem); end
    if (busy !== 1'b0) begin bad++; $display("FAIL midrst busy got=%b exp=0", busy); end
    if (cmd_if.cmd_ready !== 1'b0) begin bad++; $display("FAIL midrst ready got=%b exp=0", cmd_if.cmd_ready); end
    @(posedge Clock);
    #1;
    Reset            = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    @(negedge Clock);
    total += 3;
    if (busy !== 1'b0) begin bad++; $display("FAIL midrst busy_after got=%b exp=0", busy); end
    if (cmd_if.cmd_ready !== 1'b1) begin bad++; $display("FAIL midrst ready_after got=%b exp=1", cmd_if.cmd_ready); end
    if (ring_out !== 4'b0001) begin bad++; $display("FAIL midrst ring_after got=%b exp=0001", ring_out); end
    model_ring = 4'b0001;
  endtask

  task automatic test_back_to_back();
    run_cmd("b2b_a", 1'b1, 3, 0, 4'b1000, -1, 1'b0);
    run_cmd("b2b_b", 1'b0, 2, 1, 4'b0000, -1, 1'b0);
    run_cmd("b2b_c", 1'b0, 3, 0, 4'b0101, -1, 1'b0);
  endtask

  initial begin
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_dir   = 1'b0;
    cmd_if.cmd_steps = 8'd0;
    cmd_if.cmd_div   = 8'd0;
    cmd_if.cmd_seed  = 4'b0;
    model_ring       = 4'b0001;
    test_reset();
    test_rotate_msb();
    test_rotate_lsb_div();
    test_zero_steps();
    test_abort();
    test_reset_mid_run();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ring_seq_ctrl.md
Name: ring_seq_ctrl

Overview:
Command-driven sequencer for a RING_W-bit rotating ring register.
- Accepts a command (seed pattern, direction, step count, per-step clock divider) over a valid/ready handshake.
- Loads the ring, rotates it the requested number of times at the programmed rate, then pulses done.
- Sits between the user-project control side (LA / Wishbone decode) and the GPIO-facing ring output.

Parameters:
RING_W, 4, ring width in bits (>=2)
STEP_W, 8, width of step count
DIV_W, 8, width of divider; rotation occurs every (div+1) clocks

Ports:
Clock  in  1  system clock, all state on rising edge
Reset  in  1  reset Reset, synchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command
cmd_dir  in  1  0 = rotate toward MSB, 1 = rotate toward LSB
cmd_steps  in  STEP_W  number of rotations to perform
cmd_div  in  DIV_W  clocks per rotation minus 1
cmd_seed  in  RING_W  initial ring pattern; 0 means use RING_RESET_VAL
abort  in  1  cancel the active sequence
ring_out  out  RING_W  current ring value
busy  out  1  high whenever state != IDLE
done_pulse  out  1  one-cycle pulse on normal completion
step_rem  out  STEP_W  remaining rotations; 0 in IDLE

Behaviour:
- Reset (sync, on edge with Reset=1): state=IDLE, ring_out=RING_RESET_VAL (LSB one-hot, 4'b0001), step_rem=0, busy=0, done_pulse=0. Reset overrides everything, including mid-sequence.
- cmd_ready = (state==IDLE) && !Reset. Command accepted on an edge with cmd_valid && cmd_ready; dir/steps/div/seed latched at that edge.
- States:
  - IDLE -> LOAD on accept.
  - LOAD (1 cycle): ring <= (seed==0 ? RING_RESET_VAL : seed); divcnt <= div; step_rem <= steps. Next state is DONE if steps==0, else RUN.
  - RUN, each edge:
    - if divcnt != 0: divcnt--.
    - else: rotate ring, step_rem--, divcnt <= div; if step_rem was 1 -> DONE.
  - DONE (1 cycle): done_pulse=1 (decoded from state). -> IDLE.
- Rotation rules:
  - dir=0: {r[W-2:0], r[W-1]}
  - dir=1: {r[0], r[W-1:1]}
  - Non-one-hot seeds are rotated verbatim; no correction.
- Timing, accept at edge E with div=D, steps=N>0:
  - Ring loaded at E+1.
  - Rotation i at edge E+1+(D+1)*i, for i=1..N.
  - done_pulse high in the cycle after the last rotation.
  - cmd_ready high again after edge E+2+(D+1)*N.
- Abort:
  - Sampled in LOAD/RUN: next state IDLE, ring holds its current value, no rotation that edge (abort beats rotation), step_rem=0, no done_pulse.
  - Ignored in IDLE and DONE; DONE still pulses.
- Ring holds its value in IDLE across commands. cmd_* are don't-care when not accepted.
- step_rem and divcnt never wrap. Maximum case is steps=2^STEP_W-1 with div=2^DIV_W-1, which completes normally.

Decomposition:
- Package ring_seq_pkg holds:
  - state enum {IDLE, LOAD, RUN, DONE}
  - DIR_MSB=0, DIR_LSB=1
  - RING_RESET_VAL (one-hot bit 0, width RING_W)
- Sub-module ring_shift_reg:
  - ports: Clock, Reset, load, load_val, shift_en, dir, q
  - sync reset to RING_RESET_VAL
  - load has priority over shift_en
- The controller (FSM, divider, step counter, handshake) instantiates ring_shift_reg once.

Test Plan:
1. Reset held 2 cycles, then released → ring_out=0001, cmd_ready=1, busy=0, done_pulse=0.
2. Command seed=0, dir=0, steps=5, div=0 → ring sequence 0001,0010,0100,1000,0001,0010 on consecutive edges; done_pulse for exactly 1 cycle after the last rotation; step_rem counts 5..0.
3. Command seed=1011, dir=1, steps=2, div=2 → rotations 3 clocks apart: 1101 then 1110; cmd_ready deasserted from accept until after the DONE cycle.
4. Command steps=0 → ring loaded with seed, LOAD→DONE, done_pulse asserted, no rotation.
5. Abort asserted in RUN on the same edge a rotation is due → no rotation, ring frozen, no done_pulse, cmd_ready=1 next cycle. Abort in DONE → done_pulse still asserted.
6. Reset asserted mid-RUN (steps=200, div=7) → next cycle ring_out=0001, IDLE, step_rem=0; cmd_valid held high during Reset is not accepted.
